// File: rtl/bram_stream_reader_if.sv
// Bundle of the control, BRAM read-port and AXI4-Stream signals of
// bram_stream_reader. The master modport is the reader's side, the slave
// modport is the side of whatever drives the BRAM and sinks the stream.
//
// Stream handshake: a beat transfers on a rising clock edge where
// m_axis_tvalid and m_axis_tready are both high. Once m_axis_tvalid is
// high it stays high, and m_axis_tdata/m_axis_tlast stay unchanged, until
// that edge; only rst may withdraw a pending beat. m_axis_tready may change
// freely.
interface bram_stream_reader_if #(
  parameter int BRAM_WIDTH = 13,
  parameter int DATA_WIDTH = 32
);
  logic                  start_read;
  logic [BRAM_WIDTH-1:0] bram_addr;
  logic                  bram_en;
  logic [DATA_WIDTH-1:0] bram_rddata;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  busy;
  logic                  done;

  modport master (
    input  start_read, bram_rddata, m_axis_tready,
    output bram_addr, bram_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           busy, done
  );

  modport slave (
    output start_read, bram_rddata, m_axis_tready,
    input  bram_addr, bram_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
           busy, done
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Sweeps the acquisition BRAM once per start_read (addresses 0 .. all-ones),
// follows the fixed BRAM read latency with a valid/last shift register and
// streams the words out through a small first-word-fall-through FIFO.
// Reads are only issued while the FIFO is guaranteed to have room for
// every word already in flight, so BRAM data never needs to be stalled.
module bram_stream_reader #(
  parameter int BRAM_WIDTH   = 13,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_stream_reader_if.master bus,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  // Outstanding words can reach 2*FIFO_DEPTH in the sum below, hence +2.
  localparam int CW = PW + 2;
  localparam logic [BRAM_WIDTH-1:0] ADDR_LAST = '1;

  state_t                  state_q;
  logic [BRAM_WIDTH-1:0]   cnt_q;
  logic [BRAM_WIDTH-1:0]   addr_q;
  logic                    en_q;
  logic                    last_q;
  logic                    busy_q;
  logic                    done_q;

  logic [READ_LATENCY-1:0] sr_v_q;
  logic [READ_LATENCY-1:0] sr_l_q;

  logic [DATA_WIDTH:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]           rd_ptr_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [PW:0]             count_q;

  logic                    tvalid;
  logic                    pop;
  logic                    push;
  logic                    head_last;
  logic [CW-1:0]           outstanding;
  logic                    credit;

  assign tvalid    = (count_q != '0);
  assign pop       = tvalid & bus.m_axis_tready;
  assign push      = sr_v_q[READ_LATENCY-1];
  assign head_last = mem_q[rd_ptr_q][DATA_WIDTH];

  // Words that will occupy the FIFO next cycle: the read issued now, reads
  // in the latency pipe and queued words, less the beat leaving now.
  always_comb begin
    outstanding = CW'(en_q);
    for (int i = 0; i < READ_LATENCY; i++) begin
      outstanding = outstanding + CW'(sr_v_q[i]);
    end
    outstanding = outstanding + CW'(count_q) - CW'(pop);
    credit      = (outstanding < CW'(FIFO_DEPTH));
  end

  // Sweep controller with registered BRAM strobe, busy and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // The done cycle is the tail of the previous sweep, so a start
          // arriving together with done is dropped.
          if (bus.start_read && !done_q) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            en_q    <= 1'b1;
            addr_q  <= '0;
            last_q  <= (ADDR_LAST == '0);
            cnt_q   <= BRAM_WIDTH'(1);
          end
        end
        READ: begin
          if (credit) begin
            en_q   <= 1'b1;
            addr_q <= cnt_q;
            last_q <= (cnt_q == ADDR_LAST);
            if (cnt_q == ADDR_LAST) begin
              state_q <= DRAIN;
            end else begin
              cnt_q <= cnt_q + BRAM_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          // The last-flagged word is the final one of the sweep, so its
          // handshake means the pipe and FIFO are empty.
          if (pop && head_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Latency pipe: one valid/last pair per issued read, never stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_v_q <= '0;
      sr_l_q <= '0;
    end else begin
      sr_v_q[0] <= en_q;
      sr_l_q[0] <= last_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        sr_v_q[i] <= sr_v_q[i-1];
        sr_l_q[i] <= sr_l_q[i-1];
      end
    end
  end

  // Output FIFO storing {last, data}; head is presented combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {sr_l_q[READ_LATENCY-1], bus.bram_rddata};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign bus.bram_addr     = addr_q;
  assign bus.bram_en       = en_q;
  assign bus.m_axis_tvalid = tvalid;
  assign bus.m_axis_tdata  = tvalid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
  assign bus.m_axis_tlast  = tvalid & head_last;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader with a 16-word BRAM (data = addr + 0x100).
// dut2 (latency 2) gets the table-driven sweep and the multi-cycle corner
// sequences; dut1 and dut4 cover read latencies 1 and 4.
module tb_bram_stream_reader;

  logic clk;
  logic rst;
  logic [1:0] st1, st2, st4;

  int cyc;
  int n_cmp;
  int n_bad;

  bram_stream_reader_if #(.BRAM_WIDTH(4), .DATA_WIDTH(32)) b1 ();
  bram_stream_reader_if #(.BRAM_WIDTH(4), .DATA_WIDTH(32)) b2 ();
  bram_stream_reader_if #(.BRAM_WIDTH(4), .DATA_WIDTH(32)) b4 ();

  bram_stream_reader #(.BRAM_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .FIFO_DEPTH(8))
    dut1 (.clk(clk), .rst(rst), .bus(b1.master), .state_o(st1));
  bram_stream_reader #(.BRAM_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .FIFO_DEPTH(8))
    dut2 (.clk(clk), .rst(rst), .bus(b2.master), .state_o(st2));
  bram_stream_reader #(.BRAM_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(4), .FIFO_DEPTH(8))
    dut4 (.clk(clk), .rst(rst), .bus(b4.master), .state_o(st4));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- BRAM models ----------------
  logic [31:0] p1 [1];
  logic [31:0] p2 [2];
  logic [31:0] p4 [4];

  always @(posedge clk) begin
    p1[0] <= b1.bram_en ? (32'h100 + {28'd0, b1.bram_addr}) : 32'hDEAD0000;
    p2[0] <= b2.bram_en ? (32'h100 + {28'd0, b2.bram_addr}) : 32'hDEAD0000;
    p2[1] <= p2[0];
    p4[0] <= b4.bram_en ? (32'h100 + {28'd0, b4.bram_addr}) : 32'hDEAD0000;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end

  assign b1.bram_rddata = p1[0];
  assign b2.bram_rddata = p2[1];
  assign b4.bram_rddata = p4[3];

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // One sweep on dut2 with a scoreboard. mode 0: tready=1, 1: tready
  // toggling, 2: tready=0 for the first 30 cycles. restart_at re-pulses
  // start mid-sweep; start_on_done pulses start in the done cycle.
  task automatic sweep(input int mode, input int restart_at, input bit start_on_done,
                       input string tag);
    logic [31:0] exp_q[$];
    int beats, lasts, dones, issued, max_out, en_early, na, k, after;
    bit fin;
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + i);
    beats = 0; lasts = 0; dones = 0; issued = 0; max_out = 0;
    en_early = 0; na = 0; k = 0; after = 0; fin = 1'b0;
    tick();
    cyc = 0;
    while (!fin && k < 400) begin
      b2.start_read = (k == 0) || (k == restart_at) || (start_on_done && b2.done);
      case (mode)
        1:       b2.m_axis_tready = (k % 2 == 0);
        2:       b2.m_axis_tready = (k >= 30);
        default: b2.m_axis_tready = 1'b1;
      endcase
      if (b2.bram_en) begin
        chk({tag, " addr"}, {28'd0, b2.bram_addr}, na);
        na = na + 1;
        issued = issued + 1;
        if (k >= 1 && k <= 30) en_early = en_early + 1;
      end
      if (issued - beats > max_out) max_out = issued - beats;
      if (b2.m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          chk({tag, " extra_beat"}, b2.m_axis_tdata, 32'hFFFFFFFF);
        end else begin
          chk({tag, " data"}, b2.m_axis_tdata, exp_q[0]);
          chk({tag, " tlast"}, b2.m_axis_tlast, (exp_q.size() == 1));
          if (b2.m_axis_tready) begin
            void'(exp_q.pop_front());
            beats = beats + 1;
            if (b2.m_axis_tlast) lasts = lasts + 1;
          end
        end
      end
      if (b2.done) dones = dones + 1;
      if (dones > 0) after = after + 1;
      if (after >= 2) begin
        chk({tag, " idle_busy"}, b2.busy, 0);
        chk({tag, " idle_state"}, st2, 0);
      end
      fin = (after >= 3);
      k = k + 1;
      if (!fin) tick();
    end
    b2.start_read = 1'b0;
    b2.m_axis_tready = 1'b1;
    chk({tag, " finished"}, fin, 1);
    chk({tag, " beats"}, beats, 16);
    chk({tag, " tlast_count"}, lasts, 1);
    chk({tag, " done_count"}, dones, 1);
    chk({tag, " leftover"}, exp_q.size(), 0);
    chk({tag, " credit_bound"}, (max_out <= 8), 1);
    if (mode == 2) chk({tag, " reads_before_drain"}, en_early, 8);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        start;
    logic        tready;
    logic        en;
    logic [3:0]  addr;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [22];

  // ---------------- main sequence ----------------
  initial begin
    int f1, f4, n1, n4, l1, l4;
    cyc = 0; n_cmp = 0; n_bad = 0;
    rst = 1'b1;
    b1.start_read = 1'b0; b2.start_read = 1'b0; b4.start_read = 1'b0;
    b1.m_axis_tready = 1'b1; b2.m_axis_tready = 1'b1; b4.m_axis_tready = 1'b1;

    // Basic sweep at latency 2 with tready held high.
    for (int k = 0; k < 22; k++) begin
      tbl[k].start  = (k == 0);
      tbl[k].tready = 1'b1;
      tbl[k].en     = (k >= 1 && k <= 16);
      tbl[k].addr   = (k >= 1 && k <= 16) ? 4'(k - 1) : 4'd0;
      tbl[k].tvalid = (k >= 4 && k <= 19);
      tbl[k].tdata  = (k >= 4 && k <= 19) ? 32'h100 + 32'(k - 4) : 32'd0;
      tbl[k].tlast  = (k == 19);
      tbl[k].busy   = (k >= 1 && k <= 19);
      tbl[k].done   = (k == 20);
    end

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_addr",   {28'd0, b2.bram_addr}, 0);
    chk("rst_en",     b2.bram_en, 0);
    chk("rst_tvalid", b2.m_axis_tvalid, 0);
    chk("rst_tlast",  b2.m_axis_tlast, 0);
    chk("rst_tdata",  b2.m_axis_tdata, 0);
    chk("rst_busy",   b2.busy, 0);
    chk("rst_done",   b2.done, 0);
    chk("rst_state",  st2, 0);
    chk("rst_l1_tvalid", b1.m_axis_tvalid, 0);
    chk("rst_l4_busy",   b4.busy, 0);

    for (int k = 0; k < 22; k++) begin
      tick();
      if (k == 0) cyc = 0;
      b2.start_read    = tbl[k].start;
      b2.m_axis_tready = tbl[k].tready;
      chk("tbl_en",     b2.bram_en, tbl[k].en);
      if (tbl[k].en) chk("tbl_addr", {28'd0, b2.bram_addr}, {28'd0, tbl[k].addr});
      chk("tbl_tvalid", b2.m_axis_tvalid, tbl[k].tvalid);
      if (tbl[k].tvalid) chk("tbl_tdata", b2.m_axis_tdata, tbl[k].tdata);
      chk("tbl_tlast",  b2.m_axis_tlast, tbl[k].tlast);
      chk("tbl_busy",   b2.busy, tbl[k].busy);
      chk("tbl_done",   b2.done, tbl[k].done);
    end
    b2.start_read = 1'b0;

    sweep(1, -1, 1'b0, "toggle");
    sweep(2, -1, 1'b0, "stall");
    sweep(0, 6, 1'b1, "restart");
    sweep(0, -1, 1'b0, "second");

    // Reset in the middle of a sweep.
    tick();
    cyc = 0;
    b2.start_read = 1'b1;
    b2.m_axis_tready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      b2.start_read = 1'b0;
    end
    chk("mid_rst_en_before", b2.bram_en, 1);
    chk("mid_rst_busy_before", b2.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tvalid", b2.m_axis_tvalid, 0);
    chk("mid_rst_en",     b2.bram_en, 0);
    chk("mid_rst_busy",   b2.busy, 0);
    chk("mid_rst_state",  st2, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_rst_no_done",   b2.done, 0);
      chk("mid_rst_no_tvalid", b2.m_axis_tvalid, 0);
    end
    sweep(0, -1, 1'b0, "post_rst");

    // Read latency 1 and 4 side by side.
    f1 = -1; f4 = -1; n1 = 0; n4 = 0; l1 = 0; l4 = 0;
    tick();
    cyc = 0;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) tick();
      b1.start_read = (k == 0);
      b4.start_read = (k == 0);
      if (b1.m_axis_tvalid) begin
        if (f1 < 0) f1 = k;
        chk("l1_data",  b1.m_axis_tdata, 32'h100 + 32'(n1));
        chk("l1_tlast", b1.m_axis_tlast, (n1 == 15));
        n1 = n1 + 1;
        l1 = k;
      end
      if (b4.m_axis_tvalid) begin
        if (f4 < 0) f4 = k;
        chk("l4_data",  b4.m_axis_tdata, 32'h100 + 32'(n4));
        chk("l4_tlast", b4.m_axis_tlast, (n4 == 15));
        n4 = n4 + 1;
        l4 = k;
      end
    end
    chk("l1_first_valid", f1, 3);
    chk("l4_first_valid", f4, 6);
    chk("l1_beats", n1, 16);
    chk("l4_beats", n4, 16);
    chk("l1_span",  l1 - f1, 15);
    chk("l4_span",  l4 - f4, 15);
    chk("l1_idle",  b1.busy, 0);
    chk("l4_idle",  b4.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
